// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode valid/ready channel carrying the head instruction and its PC.
interface fetch_if;
  import fetch_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input  out_ready);
  modport slave  (input  out_valid, input  out_instr, input  out_pc, output out_ready);

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; head is read from the flops.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  // Flush wins; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC mux, and fetch queue toward decode.
// Optional misaligned-redirect trap is enabled with `define FETCH_MISALIGN_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  fetch_if.master            dec,
  output logic               fetch_fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    wdata;
  logic            valid;
  logic            push;
  logic            pop;
  logic            halt;

`ifdef FETCH_MISALIGN_EN
  logic fault_q, fault_d;

  // Sticky until reset; fetching stops but queued entries still drain.
  always_comb begin
    fault_d = fault_q;
    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign halt        = fault_q;
  assign fetch_fault = fault_q;
`else
  assign halt        = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Redirect masks the head and blocks the write, so the flush drops everything.
  always_comb begin
    valid = (count != '0) && !redirect;
    pop   = valid && dec.out_ready;
    push  = !redirect && !halt && ((count < CW'(DEPTH)) || pop);
    pc_d  = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_next(pc_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign wdata = '{pc: pc_q, instr: imem_instr};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  assign imem_addr     = pc_q;
  assign dec.out_valid = valid;
  assign dec.out_instr = head.instr;
  assign dec.out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs are queued by stimulus, a monitor pops on handshakes.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  logic [31:0] w_addr, w_instr;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_fault;

  fetch_if dec_if ();
  fetch_if wrap_if ();

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q [$];

  always #5 clock = ~clock;

  // Instruction memory model: small code region, NOPs elsewhere.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a >= 32'h0000_0100) return NOP;
    return {a[31:2], 2'b00} ^ 32'h1357_0000;
  endfunction

  assign imem_instr = mem_f(imem_addr);
  assign w_instr    = mem_f(w_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec         (dec_if.master),
    .fetch_fault (fetch_fault)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (w_addr),
    .imem_instr  (w_instr),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .dec         (wrap_if.master),
    .fetch_fault (w_fault)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted head must match the next queued PC and its memory word.
  task automatic monitor();
    logic [31:0] p;
    forever begin
      @(negedge clock);
      if (!reset && dec_if.out_valid && dec_if.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got pc %h, expected no transfer", dec_if.out_pc);
        end else begin
          p = exp_q.pop_front();
          chk("sb_pc", dec_if.out_pc, p);
          chk("sb_instr", dec_if.out_instr, mem_f(p));
        end
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    redirect           = 1'b0;
    redirect_pc        = 32'h0;
    w_redirect         = 1'b0;
    w_redirect_pc      = 32'h0;
    dec_if.out_ready   = 1'b0;
    wrap_if.out_ready  = 1'b1;
    fork
      monitor();
    join_none

    #2;
    chk("rst_valid", 32'(dec_if.out_valid), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_out_pc", dec_if.out_pc, 32'h0);
    chk("rst_out_instr", dec_if.out_instr, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);

    // Accepted sequence: 0x00..0x30 before the redirect, 0x38..0x4C after it.
    for (int i = 0; i < 13; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h38 + 32'(i * 4));

    @(posedge clock);
    #1;
    reset = 1'b0;

    tick();
    chk("first_valid", 32'(dec_if.out_valid), 32'h1);
    chk("first_pc", dec_if.out_pc, 32'h0);
    chk("first_instr", dec_if.out_instr, mem_f(32'h0));
    chk("first_addr", imem_addr, 32'h4);
    tick();
    chk("bp_addr", imem_addr, 32'h8);
    tick();
    tick();
    chk("bp_hold_addr", imem_addr, 32'h8);
    chk("bp_valid", 32'(dec_if.out_valid), 32'h1);
    dec_if.out_ready = 1'b1;

    repeat (6) tick();
    chk("stream_addr", imem_addr, 32'h20);
    repeat (7) tick();
    chk("pre_redir_addr", imem_addr, 32'h3C);
    chk("pre_redir_head", dec_if.out_pc, 32'h34);
    redirect    = 1'b1;
    redirect_pc = 32'h38;
    #1;
    chk("redir_valid", 32'(dec_if.out_valid), 32'h0);
    tick();
    redirect = 1'b0;
    chk("redir_addr", imem_addr, 32'h38);
    chk("redir_valid2", 32'(dec_if.out_valid), 32'h0);
    tick();
    chk("post_valid", 32'(dec_if.out_valid), 32'h1);
    chk("post_pc", dec_if.out_pc, 32'h38);
    repeat (6) tick();
    dec_if.out_ready = 1'b0;
    tick();
    tick();
    chk("full_addr", imem_addr, 32'h58);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset in the middle of a cycle with the queue full.
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_valid", 32'(dec_if.out_valid), 32'h0);
    chk("mr_addr", imem_addr, 32'h0);
    chk("mr_out_pc", dec_if.out_pc, 32'h0);
    chk("mr_out_instr", dec_if.out_instr, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    tick();
    chk("rel_valid", 32'(dec_if.out_valid), 32'h1);
    chk("rel_pc", dec_if.out_pc, 32'h0);
    chk("rel_instr", dec_if.out_instr, mem_f(32'h0));
    chk("wrap_pc0", wrap_if.out_pc, 32'hFFFF_FFF8);
    chk("wrap_instr0", wrap_if.out_instr, NOP);
    tick();
    chk("wrap_pc1", wrap_if.out_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", w_addr, 32'h0);
    chk("full2_addr", imem_addr, 32'h8);

    redirect    = 1'b1;
    redirect_pc = 32'h42;
    #1;
    chk("mis_redir_valid", 32'(dec_if.out_valid), 32'h0);
    tick();
    redirect = 1'b0;
    chk("wrap_pc2", wrap_if.out_pc, 32'h0);
    chk("wrap_instr2", wrap_if.out_instr, mem_f(32'h0));
    chk("mis_addr", imem_addr, 32'h42);
    chk("mis_valid", 32'(dec_if.out_valid), 32'h0);
`ifdef FETCH_MISALIGN_EN
    chk("mis_fault", 32'(fetch_fault), 32'h1);
    dec_if.out_ready = 1'b1;
    repeat (3) tick();
    chk("mis_frozen_addr", imem_addr, 32'h42);
    chk("mis_drained_valid", 32'(dec_if.out_valid), 32'h0);
    chk("mis_fault_sticky", 32'(fetch_fault), 32'h1);
    dec_if.out_ready = 1'b0;
`else
    chk("mis_fault", 32'(fetch_fault), 32'h0);
    tick();
    chk("mis_load_valid", 32'(dec_if.out_valid), 32'h1);
    chk("mis_load_pc", dec_if.out_pc, 32'h42);
    chk("mis_load_addr", imem_addr, 32'h46);
    chk("mis_fault2", 32'(fetch_fault), 32'h0);
`endif

    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("end_fault", 32'(fetch_fault), 32'h0);
    chk("end_valid", 32'(dec_if.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of the word-indexed, combinational-read instruction memory.
- Owns the program counter and drives the memory address.
- Captures the returned instruction word together with its PC into a small FIFO.
- Presents entries to decode with a valid/ready handshake.
- Accepts redirects (taken branch, jal) from execute, which flush the queue and reload the PC.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals current PC.
- imem_instr  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  new PC when redirect=1.
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode accepts head entry.
- out_instr  out  32  head instruction word.
- out_pc  out  32  PC of head instruction.
- fetch_fault  out  1  misaligned redirect flag (FETCH_MISALIGN_EN only).

Behaviour:
- Clock and reset: one clock, clock; reset is asynchronous and active-high.
- Reset effects: pc=RESET_PC and count=0 immediately.
- Output values under reset: out_valid=0, out_instr=0, out_pc=0, fetch_fault=0.
- Address: imem_addr = pc, combinational from the PC register. Memory indexing by addr>>2 is the memory's responsibility.
- pop = out_valid & out_ready.
- push = !redirect & (count<DEPTH | pop). Writing into a full FIFO is allowed only when it is also popped the same cycle.
- On push: store {pc, imem_instr} at the tail; pc <= pc+4. Addition is modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- No push (full, no pop): pc holds and imem_addr stays stable.
- Latency: a word is visible on out_* one cycle after its address appears on imem_addr.
- Throughput: 1 instruction/cycle with out_ready held high.
- out_valid = (count!=0) & !redirect. Head data is driven from the FIFO head; when count=0, out_instr/out_pc are don't-care and the bench must not check them.
- Redirect has priority over push and pop. On the next edge: count<=0, pointers reset, pc<=redirect_pc. No entry is consumed or written that cycle.
- Redirect with an empty FIFO: same behaviour as above, only pc changes.
- First cycle after redirect: imem_addr=redirect_pc. out_valid=1 from the following cycle.
- Counters: count is $clog2(DEPTH)+1 bits. Read and write pointers are $clog2(DEPTH) bits with natural wrap.
- Simultaneous push and pop: count is unchanged.
- redirect_pc[1:0] is not checked without the optional feature. The PC is loaded as given.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined: when redirect=1 and redirect_pc[1:0]!=0, fetch_fault is set (registered) on the next edge and stays set until reset. While fetch_fault=1: push is suppressed, pc holds, and the FIFO drains normally to decode.
- Undefined: fetch_fault is tied to 0 and no alignment check exists.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN=32 and INSTR_W=32.
  - DEFAULT_RESET_PC.
  - NOP constant 32'h00000013.
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One natural sub-module: fetch_fifo. It is a DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop and flush inputs, count and head outputs, and an async active-high reset. fetch_unit holds the PC, next-PC mux and push/valid logic.

Test Plan:
- Reset release: assert reset mid-run with count=2 -> out_valid=0 and imem_addr=0x00000000 immediately; first edge after release -> out_valid=1, out_pc=0x0, out_instr=mem[0].
- Back-pressure: out_ready=0 from release -> after 2 edges count=2, imem_addr holds 0x00000008. Raise out_ready -> out_pc sequence 0x0, 0x4, 0x8, … with no gap or duplicate.
- Streaming with full+pop: out_ready=1 continuously -> one new out_pc per cycle, step +4. Verify full-and-pop cycles still push.
- Redirect: at pc=0x3C with FIFO holding 0x34 and 0x38, pulse redirect with redirect_pc=0x38 (backward branch) -> out_valid=0 that cycle; next cycle imem_addr=0x38; cycle after, out_pc=0x38. Stale entries never appear.
- Wrap-around: RESET_PC=0xFFFFFFF8, out_ready=1 -> out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- FETCH_MISALIGN_EN: redirect_pc=0x00000042 -> fetch_fault=1 next cycle; pc frozen at 0x42; out_valid=0 after the FIFO drains; the fault clears only on reset.
